// File: rtl/prg_mem_bridge.sv
// prg_mem_bridge: turns mapper PRG accesses into req/ack cycles on the shared cart memory port.
// Holds one in-flight access, one pending access, and a single-entry read buffer that serves repeated reads.
module prg_mem_bridge #(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] OPEN_BUS       = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [21:0] prg_aout,
  input  logic        prg_allow,
  input  logic [7:0]  prg_din,
  output logic [7:0]  prg_dout,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        overrun,
  output logic        timeout_err
);
  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  // state | meaning:  IDLE | nothing outstanding;  REQ | mem_req held;  GAP | one low cycle before next REQ
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state_q, state_d;
  logic          cur_we_q, cur_we_d;
  logic [21:0]   cur_addr_q, cur_addr_d;
  logic [7:0]    cur_wdata_q, cur_wdata_d;
  logic          pend_v_q, pend_v_d;
  logic          pend_we_q, pend_we_d;
  logic [21:0]   pend_addr_q, pend_addr_d;
  logic [7:0]    pend_wdata_q, pend_wdata_d;
  logic          rbuf_v_q, rbuf_v_d;
  logic [21:0]   rbuf_addr_q, rbuf_addr_d;
  logic [7:0]    rbuf_data_q, rbuf_data_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    dout_q, dout_d;
  logic          overrun_q, overrun_d;
  logic          tmo_err_q, tmo_err_d;

  logic acc, wr_conflict, hit, queue, done_ack, done_tmo;

  always_comb begin
    state_d      = state_q;
    cur_we_d     = cur_we_q;
    cur_addr_d   = cur_addr_q;
    cur_wdata_d  = cur_wdata_q;
    pend_v_d     = pend_v_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    rbuf_v_d     = rbuf_v_q;
    rbuf_addr_d  = rbuf_addr_q;
    rbuf_data_d  = rbuf_data_q;
    tmo_d        = tmo_q;
    dout_d       = dout_q;
    overrun_d    = overrun_q;
    tmo_err_d    = tmo_err_q;

    acc = ce & (prg_read | prg_write) & prg_allow;
    // A read must not bypass a write to the same address that is still on its way to memory.
    wr_conflict = ((state_q != IDLE) && cur_we_q && (cur_addr_q == prg_aout)) ||
                  (pend_v_q && pend_we_q && (pend_addr_q == prg_aout));
    hit      = acc & ~prg_write & rbuf_v_q & (rbuf_addr_q == prg_aout) & ~wr_conflict;
    queue    = acc & ~hit;
    done_ack = (state_q == REQ) & mem_ack;
    done_tmo = (state_q == REQ) & ~mem_ack & (tmo_q == TMO_LAST);

    case (state_q)
      IDLE: begin
        if (queue) begin
          cur_we_d    = prg_write;
          cur_addr_d  = prg_aout;
          cur_wdata_d = prg_din;
          tmo_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        tmo_d = tmo_q + CW'(1);
        if (done_ack || done_tmo) begin
          if (pend_v_q) begin
            cur_we_d     = pend_we_q;
            cur_addr_d   = pend_addr_q;
            cur_wdata_d  = pend_wdata_q;
            pend_v_d     = queue;
            pend_we_d    = prg_write;
            pend_addr_d  = prg_aout;
            pend_wdata_d = prg_din;
            state_d      = GAP;
          end else if (queue) begin
            cur_we_d    = prg_write;
            cur_addr_d  = prg_aout;
            cur_wdata_d = prg_din;
            state_d     = GAP;
          end else begin
            state_d = IDLE;
          end
        end else if (queue) begin
          if (pend_v_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_v_d     = 1'b1;
            pend_we_d    = prg_write;
            pend_addr_d  = prg_aout;
            pend_wdata_d = prg_din;
          end
        end
      end
      GAP: begin
        state_d = REQ;
        tmo_d   = '0;
        if (queue) begin
          if (pend_v_q) begin
            overrun_d = 1'b1;
          end else begin
            pend_v_d     = 1'b1;
            pend_we_d    = prg_write;
            pend_addr_d  = prg_aout;
            pend_wdata_d = prg_din;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_ack) begin
      if (!cur_we_q) begin
        dout_d      = mem_rdata;
        rbuf_v_d    = 1'b1;
        rbuf_addr_d = cur_addr_q;
        rbuf_data_d = mem_rdata;
      end else if (rbuf_v_q && (rbuf_addr_q == cur_addr_q)) begin
        rbuf_data_d = cur_wdata_q;
      end
    end
    if (done_tmo) begin
      tmo_err_d = 1'b1;
      if (!cur_we_q) dout_d = OPEN_BUS;
    end
    if (hit) dout_d = rbuf_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_we_q     <= 1'b0;
      cur_addr_q   <= '0;
      cur_wdata_q  <= '0;
      pend_v_q     <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      rbuf_v_q     <= 1'b0;
      rbuf_addr_q  <= '0;
      rbuf_data_q  <= '0;
      tmo_q        <= '0;
      dout_q       <= 8'hFF;
      overrun_q    <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_we_q     <= cur_we_d;
      cur_addr_q   <= cur_addr_d;
      cur_wdata_q  <= cur_wdata_d;
      pend_v_q     <= pend_v_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      rbuf_v_q     <= rbuf_v_d;
      rbuf_addr_q  <= rbuf_addr_d;
      rbuf_data_q  <= rbuf_data_d;
      tmo_q        <= tmo_d;
      dout_q       <= dout_d;
      overrun_q    <= overrun_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign mem_req     = (state_q == REQ);
  assign busy        = (state_q != IDLE);
  assign mem_we      = cur_we_q;
  assign mem_addr    = cur_addr_q;
  assign mem_wdata   = cur_wdata_q;
  assign prg_dout    = dout_q;
  assign overrun     = overrun_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_prg_mem_bridge.sv
// Bench for prg_mem_bridge: directed scenario tasks plus a randomized sequence checked against
// a transaction-level model of memory contents and the read buffer.
module tb_prg_mem_bridge;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0, prg_read = 1'b0, prg_write = 1'b0, prg_allow = 1'b0;
  logic [21:0] prg_aout = '0;
  logic [7:0]  prg_din = '0;
  logic [7:0]  prg_dout;
  logic        busy, mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        overrun, timeout_err;

  int checks = 0;
  int failures = 0;
  int resp_en = 1;
  int ack_delay = 3;
  int req_cycles = 0;
  int req_starts = 0;
  logic [7:0] dev_mem [int];
  logic [7:0] model_mem [int];

  prg_mem_bridge dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .prg_read(prg_read), .prg_write(prg_write),
    .prg_aout(prg_aout), .prg_allow(prg_allow), .prg_din(prg_din), .prg_dout(prg_dout),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hA5;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [21:0] a);
    if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [7:0] model_rd(input logic [21:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return init_val(a);
  endfunction

  // Memory-side responder: acks after ack_delay request cycles, counts request activity.
  initial begin : responder
    int cnt;
    logic req_prev;
    cnt = 0;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (mem_req && !req_prev) req_starts++;
      req_prev = mem_req;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req && resp_en != 0) begin
        cnt++;
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) dev_mem[int'(mem_addr)] = mem_wdata;
          else mem_rdata = dev_rd(mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic cpu(input logic wr, input logic rd, input logic [21:0] a, input logic [7:0] d,
                     input logic allow);
    @(negedge clk);
    ce = 1'b1; prg_write = wr; prg_read = rd; prg_aout = a; prg_din = d; prg_allow = allow;
    @(negedge clk);
    ce = 1'b0; prg_write = 1'b0; prg_read = 1'b0; prg_allow = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle: busy actual=%0b required=0", tag, busy); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req actual=%0b required=0", mem_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%0b required=0", busy); end
    checks++; if (prg_dout !== 8'hFF) begin failures++; $display("FAIL rst_dout actual=%h required=ff", prg_dout); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun actual=%0b required=0", overrun); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout actual=%0b required=0", timeout_err); end
    checks++; if (mem_addr !== 22'h0) begin failures++; $display("FAIL rst_mem_addr actual=%h required=0", mem_addr); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_miss();
    int rc0, rs0;
    dev_mem[32'h004000] = 8'h5A;
    ack_delay = 3;
    rc0 = req_cycles; rs0 = req_starts;
    cpu(1'b0, 1'b1, 22'h004000, 8'h00, 1'b1);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL miss_latency mem_req actual=%0b required=1", mem_req); end
    checks++; if (mem_addr !== 22'h004000) begin failures++; $display("FAIL miss_addr actual=%h required=004000", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL miss_we actual=%0b required=0", mem_we); end
    wait_idle("miss");
    checks++; if (req_cycles - rc0 != 3) begin failures++; $display("FAIL miss_hold actual=%0d required=3", req_cycles - rc0); end
    checks++; if (req_starts - rs0 != 1) begin failures++; $display("FAIL miss_reqs actual=%0d required=1", req_starts - rs0); end
    checks++; if (prg_dout !== 8'h5A) begin failures++; $display("FAIL miss_dout actual=%h required=5a", prg_dout); end
  endtask

  task automatic test_read_hit();
    int rs0;
    rs0 = req_starts;
    cpu(1'b0, 1'b1, 22'h004000, 8'h00, 1'b1);
    checks++; if (prg_dout !== 8'h5A) begin failures++; $display("FAIL hit_dout actual=%h required=5a", prg_dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hit_busy actual=%0b required=0", busy); end
    cpu(1'b1, 1'b0, 22'h004000, 8'h33, 1'b1);
    wait_idle("hit_wr");
    checks++; if (req_starts - rs0 != 1) begin failures++; $display("FAIL hit_wr_reqs actual=%0d required=1", req_starts - rs0); end
    checks++; if (dev_rd(22'h004000) !== 8'h33) begin failures++; $display("FAIL hit_wr_mem actual=%h required=33", dev_rd(22'h004000)); end
    checks++; if (prg_dout !== 8'h5A) begin failures++; $display("FAIL hit_wr_dout actual=%h required=5a", prg_dout); end
    cpu(1'b0, 1'b1, 22'h004000, 8'h00, 1'b1);
    checks++; if (prg_dout !== 8'h33) begin failures++; $display("FAIL hit_after_wr actual=%h required=33", prg_dout); end
    repeat (3) @(negedge clk);
    checks++; if (req_starts - rs0 != 1) begin failures++; $display("FAIL hit_no_req actual=%0d required=1", req_starts - rs0); end
  endtask

  task automatic test_disallowed();
    int rs0;
    rs0 = req_starts;
    cpu(1'b1, 1'b0, 22'h3C0010, 8'h99, 1'b0);
    cpu(1'b0, 1'b1, 22'h000777, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (req_starts != rs0) begin failures++; $display("FAIL dis_reqs actual=%0d required=0", req_starts - rs0); end
    checks++; if (prg_dout !== 8'h33) begin failures++; $display("FAIL dis_dout actual=%h required=33", prg_dout); end
    checks++; if (dev_mem.exists(32'h3C0010)) begin failures++; $display("FAIL dis_mem_written actual=1 required=0"); end
    cpu(1'b0, 1'b1, 22'h004000, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (req_starts != rs0) begin failures++; $display("FAIL dis_buf_reqs actual=%0d required=0", req_starts - rs0); end
    checks++; if (prg_dout !== 8'h33) begin failures++; $display("FAIL dis_buf_dout actual=%h required=33", prg_dout); end
  endtask

  task automatic test_reset_mid_req();
    resp_en = 0;
    cpu(1'b0, 1'b1, 22'h000123, 8'h00, 1'b1);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL midrst_pre actual=%0b required=1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midrst_mem_req actual=%0b required=0", mem_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy actual=%0b required=0", busy); end
    checks++; if (prg_dout !== 8'hFF) begin failures++; $display("FAIL midrst_dout actual=%h required=ff", prg_dout); end
    @(negedge clk);
    reset_n = 1'b1;
    resp_en = 1;
    @(negedge clk);
  endtask

  task automatic test_pending();
    logic       req_s [25];
    logic [21:0] addr_s [25];
    int rs0, rises, first_fall, second_rise;
    ack_delay = 4;
    rs0 = req_starts;
    @(negedge clk);
    ce = 1'b1; prg_read = 1'b1; prg_write = 1'b0; prg_allow = 1'b1; prg_aout = 22'h001000;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) begin prg_aout = 22'h002000; end
      else if (i == 1) begin prg_read = 1'b0; prg_write = 1'b1; prg_aout = 22'h003000; prg_din = 8'hC3; end
      else if (i == 2) begin ce = 1'b0; prg_read = 1'b0; prg_write = 1'b0; prg_allow = 1'b0; end
      req_s[i] = mem_req;
      addr_s[i] = mem_addr;
    end
    rises = 0; first_fall = -1; second_rise = -1;
    for (int i = 0; i < 25; i++) begin
      if (req_s[i] && (i == 0 || !req_s[i-1])) begin
        rises++;
        if (rises == 2) second_rise = i;
      end
      if (!req_s[i] && first_fall < 0) first_fall = i;
    end
    checks++; if (rises != 2) begin failures++; $display("FAIL pend_rises actual=%0d required=2", rises); end
    checks++; if (second_rise - first_fall != 1) begin failures++; $display("FAIL pend_gap actual=%0d required=1", second_rise - first_fall); end
    checks++; if (second_rise < 0 || addr_s[second_rise < 0 ? 0 : second_rise] !== 22'h002000) begin failures++; $display("FAIL pend_addr actual=%h required=002000", addr_s[second_rise < 0 ? 0 : second_rise]); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL pend_overrun actual=%0b required=1", overrun); end
    checks++; if (prg_dout !== init_val(22'h002000)) begin failures++; $display("FAIL pend_dout actual=%h required=%h", prg_dout, init_val(22'h002000)); end
    checks++; if (dev_mem.exists(32'h003000)) begin failures++; $display("FAIL pend_dropped_written actual=1 required=0"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pend_busy actual=%0b required=0", busy); end
  endtask

  task automatic test_ordering();
    int rs0;
    ack_delay = 2;
    rs0 = req_starts;
    cpu(1'b0, 1'b1, 22'h004000, 8'h00, 1'b1);
    wait_idle("ord_fill");
    checks++; if (prg_dout !== 8'h33) begin failures++; $display("FAIL ord_fill_dout actual=%h required=33", prg_dout); end
    @(negedge clk);
    ce = 1'b1; prg_write = 1'b1; prg_read = 1'b0; prg_allow = 1'b1; prg_aout = 22'h004000; prg_din = 8'h77;
    @(negedge clk);
    prg_write = 1'b0; prg_read = 1'b1;
    @(negedge clk);
    ce = 1'b0; prg_read = 1'b0; prg_allow = 1'b0;
    wait_idle("ord");
    checks++; if (req_starts - rs0 != 3) begin failures++; $display("FAIL ord_reqs actual=%0d required=3", req_starts - rs0); end
    checks++; if (prg_dout !== 8'h77) begin failures++; $display("FAIL ord_dout actual=%h required=77", prg_dout); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ord_overrun_sticky actual=%0b required=1", overrun); end
  endtask

  task automatic test_timeout();
    int rc0, n;
    resp_en = 0;
    rc0 = req_cycles;
    cpu(1'b0, 1'b1, 22'h0ABCDE, 8'h00, 1'b1);
    n = 0;
    while (mem_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (req_cycles - rc0 != 64) begin failures++; $display("FAIL tmo_hold actual=%0d required=64", req_cycles - rc0); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag actual=%0b required=1", timeout_err); end
    checks++; if (prg_dout !== 8'hFF) begin failures++; $display("FAIL tmo_dout actual=%h required=ff", prg_dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy actual=%0b required=0", busy); end
    resp_en = 1;
  endtask

  task automatic test_random();
    logic [21:0] pool [4];
    logic        mb_v;
    logic [21:0] mb_addr;
    logic [7:0]  mb_data, exp_dout, d;
    logic [21:0] a;
    logic        wr, rd, allow;
    int          rs0, exp_reqs;
    pool[0] = 22'h000010; pool[1] = 22'h000011; pool[2] = 22'h1FFF00; pool[3] = 22'h3FFFFF;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mb_v = 1'b0; mb_addr = '0; mb_data = '0; exp_dout = 8'hFF;
    for (int it = 0; it < 60; it++) begin
      a = pool[$urandom_range(0, 3)];
      wr = ($urandom_range(0, 2) == 0);
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      allow = ($urandom_range(0, 7) != 0);
      d = 8'($urandom);
      ack_delay = $urandom_range(1, 6);
      rs0 = req_starts;
      cpu(wr, rd, a, d, allow);
      wait_idle("rand");
      exp_reqs = 0;
      if (allow) begin
        if (wr) begin
          exp_reqs = 1;
          model_mem[int'(a)] = d;
          if (mb_v && mb_addr == a) mb_data = d;
        end else if (mb_v && mb_addr == a) begin
          exp_dout = mb_data;
        end else begin
          exp_reqs = 1;
          exp_dout = model_rd(a);
          mb_v = 1'b1; mb_addr = a; mb_data = exp_dout;
        end
      end
      checks++; if (req_starts - rs0 != exp_reqs) begin failures++; $display("FAIL rand_reqs it=%0d addr=%h wr=%0b allow=%0b actual=%0d required=%0d", it, a, wr, allow, req_starts - rs0, exp_reqs); end
      checks++; if (prg_dout !== exp_dout) begin failures++; $display("FAIL rand_dout it=%0d addr=%h wr=%0b allow=%0b actual=%h required=%h", it, a, wr, allow, prg_dout, exp_dout); end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun actual=%0b required=0", overrun); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rand_timeout actual=%0b required=0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_disallowed();
    test_reset_mid_req();
    test_pending();
    test_ordering();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
